// File: rtl/conv_layer_seq_if.sv
// Handshake and tile-descriptor bundle between the layer sequencer and
// its environment (host control side and tile engine side).
//   master : sequencer view (drives busy/done/tile_start/tile fields/perf)
//   slave  : environment view (drives layer_start/layer_abort/tile_done)
interface conv_layer_seq_if #(
    parameter int AW = 32
);
    logic          layer_start;
    logic          layer_abort;
    logic          layer_busy;
    logic          layer_done;
    logic          tile_start;
    logic          tile_done;
    logic [AW-1:0] tile_base_n;
    logic [AW-1:0] tile_base_m;
    logic [AW-1:0] tile_base_row;
    logic [AW-1:0] tile_base_col;
    logic [AW-1:0] tile_size_n;
    logic [AW-1:0] tile_size_m;
    logic [AW-1:0] tile_size_row;
    logic [AW-1:0] tile_size_col;
    logic          tile_first_m;
    logic          tile_last_m;
    logic [31:0]   perf_cycles;
    logic [15:0]   perf_tiles;

    modport master (
        input  layer_start, layer_abort, tile_done,
        output layer_busy, layer_done, tile_start,
        output tile_base_n, tile_base_m, tile_base_row, tile_base_col,
        output tile_size_n, tile_size_m, tile_size_row, tile_size_col,
        output tile_first_m, tile_last_m, perf_cycles, perf_tiles
    );

    modport slave (
        output layer_start, layer_abort, tile_done,
        input  layer_busy, layer_done, tile_start,
        input  tile_base_n, tile_base_m, tile_base_row, tile_base_col,
        input  tile_size_n, tile_size_m, tile_size_row, tile_size_col,
        input  tile_first_m, tile_last_m, perf_cycles, perf_tiles
    );
endinterface

// File: rtl/conv_layer_seq.sv
// Layer tile sequencer: walks n/row/col/m tiles (m innermost) and drives
// one tile engine through tile_start/tile_done with an inter-tile gap.
// Ports: clk, rst (sync, active-high), bus (conv_layer_seq_if.master).
// Optional macro CONV_LAYER_SEQ_PERF_EN enables perf_cycles/perf_tiles.
module conv_layer_seq #(
    parameter int AW         = 32,
    parameter int N          = 32,
    parameter int M          = 32,
    parameter int R          = 64,
    parameter int C          = 32,
    parameter int Tn         = 16,
    parameter int Tm         = 16,
    parameter int Tr         = 64,
    parameter int Tc         = 16,
    parameter int GAP_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    conv_layer_seq_if.master bus
);

    if (Tn < 1 || Tn > N || Tm < 1 || Tm > M || Tr < 1 || Tr > R ||
        Tc < 1 || Tc > C || GAP_CYCLES < 0 ||
        (N >> AW) != 0 || (M >> AW) != 0 ||
        (R >> AW) != 0 || (C >> AW) != 0) begin : g_bad_cfg
        $error("conv_layer_seq: illegal tile configuration");
    end

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [AW-1:0] DN = AW'(N);
    localparam logic [AW-1:0] DM = AW'(M);
    localparam logic [AW-1:0] DR = AW'(R);
    localparam logic [AW-1:0] DC = AW'(C);
    localparam logic [AW-1:0] TN = AW'(Tn);
    localparam logic [AW-1:0] TM = AW'(Tm);
    localparam logic [AW-1:0] TR = AW'(Tr);
    localparam logic [AW-1:0] TC = AW'(Tc);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [AW-1:0] bn_q, bn_d, bm_q, bm_d;
    logic [AW-1:0] br_q, br_d, bc_q, bc_d;

    logic busy, tile_start, layer_done;
    logic wrap_n, wrap_m, wrap_r, wrap_c, last_tile;
    logic start_ok, done_ok;

    // An index wraps once its tile reaches or passes the dimension edge.
    assign wrap_n = ({1'b0, bn_q} + {1'b0, TN}) >= {1'b0, DN};
    assign wrap_m = ({1'b0, bm_q} + {1'b0, TM}) >= {1'b0, DM};
    assign wrap_r = ({1'b0, br_q} + {1'b0, TR}) >= {1'b0, DR};
    assign wrap_c = ({1'b0, bc_q} + {1'b0, TC}) >= {1'b0, DC};
    assign last_tile = wrap_n & wrap_m & wrap_r & wrap_c;

    assign start_ok = (state_q == S_IDLE) & bus.layer_start
                    & ~bus.layer_abort;
    assign done_ok  = (state_q == S_WAIT) & bus.tile_done
                    & ~bus.layer_abort;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // GAP always lasts GAP_CYCLES+1 cycles: the extra cycle lets the
    // advanced bases settle before the next tile_start.
    always_comb begin
        state_d = state_q;
        if (bus.layer_abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:  if (bus.layer_start) state_d = S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT:  if (bus.tile_done)
                             state_d = last_tile ? S_DONE : S_GAP;
                S_GAP:   if (gap_q == '0) state_d = S_ISSUE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        tile_start = 1'b0;
        layer_done = 1'b0;
        unique case (state_q)
            S_ISSUE: begin busy = 1'b1; tile_start = 1'b1; end
            S_WAIT:  busy = 1'b1;
            S_GAP:   busy = 1'b1;
            S_DONE:  layer_done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        bn_d  = bn_q;
        bm_d  = bm_q;
        br_d  = br_q;
        bc_d  = bc_q;
        gap_d = gap_q;
        if (bus.layer_abort || start_ok) begin
            bn_d = '0;
            bm_d = '0;
            br_d = '0;
            bc_d = '0;
        end else if (done_ok && !last_tile) begin
            gap_d = GW'(GAP_CYCLES);
            // Odometer step, m innermost so partial sums chain.
            if (!wrap_m) begin
                bm_d = bm_q + TM;
            end else begin
                bm_d = '0;
                if (!wrap_c) begin
                    bc_d = bc_q + TC;
                end else begin
                    bc_d = '0;
                    if (!wrap_r) begin
                        br_d = br_q + TR;
                    end else begin
                        br_d = '0;
                        bn_d = bn_q + TN;
                    end
                end
            end
        end else if (state_q == S_GAP && gap_q != '0) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bn_q  <= '0;
            bm_q  <= '0;
            br_q  <= '0;
            bc_q  <= '0;
            gap_q <= '0;
        end else begin
            bn_q  <= bn_d;
            bm_q  <= bm_d;
            br_q  <= br_d;
            bc_q  <= bc_d;
            gap_q <= gap_d;
        end
    end

    assign bus.layer_busy    = busy;
    assign bus.layer_done    = layer_done;
    assign bus.tile_start    = tile_start;
    assign bus.tile_base_n   = bn_q;
    assign bus.tile_base_m   = bm_q;
    assign bus.tile_base_row = br_q;
    assign bus.tile_base_col = bc_q;
    // Edge tiles clip to the remainder; fields read 0 when not busy.
    assign bus.tile_size_n   = !busy ? '0 : wrap_n ? DN - bn_q : TN;
    assign bus.tile_size_m   = !busy ? '0 : wrap_m ? DM - bm_q : TM;
    assign bus.tile_size_row = !busy ? '0 : wrap_r ? DR - br_q : TR;
    assign bus.tile_size_col = !busy ? '0 : wrap_c ? DC - bc_q : TC;
    assign bus.tile_first_m  = busy & (bm_q == '0);
    assign bus.tile_last_m   = busy & wrap_m;

`ifdef CONV_LAYER_SEQ_PERF_EN
    logic [31:0] pc_q, pc_d;
    logic [15:0] pt_q, pt_d;

    always_comb begin
        pc_d = pc_q;
        pt_d = pt_q;
        if (start_ok) begin
            pc_d = '0;
            pt_d = '0;
        end else begin
            if (busy && pc_q != '1)    pc_d = pc_q + 1'b1;
            if (done_ok && pt_q != '1) pt_d = pt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            pt_q <= '0;
        end else begin
            pc_q <= pc_d;
            pt_q <= pt_d;
        end
    end

    assign bus.perf_cycles = pc_q;
    assign bus.perf_tiles  = pt_q;
`else
    assign bus.perf_cycles = '0;
    assign bus.perf_tiles  = '0;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: two instances (gap 4 and gap 0) driven by
// randomized engines and checked every cycle against a tile-list model.
module tb_conv_layer_seq;
    localparam int AW = 32;
    localparam int N = 32, M = 24, R = 20, C = 16;
    localparam int TN = 16, TM = 16, TR = 8, TC = 16;
    localparam int GAP_A = 4, GAP_B = 0;

    typedef struct packed {
        logic          busy, start, done, first, last;
        logic [AW-1:0] bn, bm, br, bc, sn, sm, sr, sc;
        logic [31:0]   pc;
        logic [15:0]   pt;
    } obs_t;

    typedef struct packed {
        logic [AW-1:0] bn, bm, br, bc, sn, sm, sr, sc;
        logic          first, last;
    } tile_t;

    typedef struct packed {
        logic        busy, start, done, wt;
        int          idx;
        int          cd;
        logic [31:0] pc;
        logic [15:0] pt;
    } mdl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g_start = 1'b0;
    logic g_abort = 1'b0;
    logic [1:0] td_v;
    bit en_inj = 1'b0;
    bit rand_lat = 1'b1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int starts [2] = '{0, 0};
    int dones  [2] = '{0, 0};
    int acc    [2] = '{0, 0};
    int spacing[2] = '{0, 0};
    mdl_t md[2] = '{default: '0};
    tile_t tl[$];
    obs_t ob[2];

    always #5 clk = ~clk;

    conv_layer_seq_if #(.AW(AW)) if_a ();
    conv_layer_seq_if #(.AW(AW)) if_b ();

    assign if_a.layer_start = g_start;
    assign if_a.layer_abort = g_abort;
    assign if_a.tile_done   = td_v[0];
    assign if_b.layer_start = g_start;
    assign if_b.layer_abort = g_abort;
    assign if_b.tile_done   = td_v[1];

    conv_layer_seq #(
        .AW(AW), .N(N), .M(M), .R(R), .C(C),
        .Tn(TN), .Tm(TM), .Tr(TR), .Tc(TC), .GAP_CYCLES(GAP_A)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(if_a.master));

    conv_layer_seq #(
        .AW(AW), .N(N), .M(M), .R(R), .C(C),
        .Tn(TN), .Tm(TM), .Tr(TR), .Tc(TC), .GAP_CYCLES(GAP_B)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b.master));

    assign ob[0] = {if_a.layer_busy, if_a.tile_start, if_a.layer_done,
        if_a.tile_first_m, if_a.tile_last_m,
        if_a.tile_base_n, if_a.tile_base_m,
        if_a.tile_base_row, if_a.tile_base_col,
        if_a.tile_size_n, if_a.tile_size_m,
        if_a.tile_size_row, if_a.tile_size_col,
        if_a.perf_cycles, if_a.perf_tiles};
    assign ob[1] = {if_b.layer_busy, if_b.tile_start, if_b.layer_done,
        if_b.tile_first_m, if_b.tile_last_m,
        if_b.tile_base_n, if_b.tile_base_m,
        if_b.tile_base_row, if_b.tile_base_col,
        if_b.tile_size_n, if_b.tile_size_m,
        if_b.tile_size_row, if_b.tile_size_col,
        if_b.perf_cycles, if_b.perf_tiles};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Cycle-level behaviour: what the sequencer must show given inputs.
    function automatic mdl_t step(mdl_t s, logic st, logic ab, logic td,
                                  logic rs, int gap);
        mdl_t n = s;
        if (rs) return '0;
        if (s.busy && s.pc != '1) n.pc = s.pc + 1;
        n.start = 1'b0;
        n.done  = 1'b0;
        if (ab) begin
            n.busy = 1'b0;
            n.wt   = 1'b0;
            n.cd   = 0;
            n.idx  = 0;
            return n;
        end
        if (!s.busy && !s.done) begin
            if (st) begin
                n.busy  = 1'b1;
                n.start = 1'b1;
                n.idx   = 0;
                n.pc    = '0;
                n.pt    = '0;
            end
        end else if (s.busy) begin
            if (s.start) begin
                n.wt = 1'b1;
            end else if (s.wt && td) begin
                n.wt = 1'b0;
                if (s.pt != '1) n.pt = s.pt + 1;
                if (s.idx == tl.size() - 1) begin
                    n.busy = 1'b0;
                    n.done = 1'b1;
                end else begin
                    n.idx = s.idx + 1;
                    n.cd  = gap + 1;
                end
            end else if (s.cd > 0) begin
                n.cd = s.cd - 1;
                if (n.cd == 0) n.start = 1'b1;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            mdl_t nx;
            if (!rst && !g_abort && td_v[d] && md[d].wt) acc[d] = cyc;
            nx = step(md[d], g_start, g_abort, td_v[d], rst,
                      (d == 0) ? GAP_A : GAP_B);
            if (!md[d].busy && nx.busy) acc[d] = 0;
            md[d] = nx;
        end
    end

    always @(negedge clk) begin : cmp_p
        tile_t e;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), ob[d].busy, md[d].busy);
            chk($sformatf("start%0d", d), ob[d].start, md[d].start);
            chk($sformatf("done%0d", d), ob[d].done, md[d].done);
            if (md[d].busy) begin
                e = tl[md[d].idx];
                chk($sformatf("bn%0d", d), ob[d].bn, e.bn);
                chk($sformatf("bm%0d", d), ob[d].bm, e.bm);
                chk($sformatf("br%0d", d), ob[d].br, e.br);
                chk($sformatf("bc%0d", d), ob[d].bc, e.bc);
                chk($sformatf("sn%0d", d), ob[d].sn, e.sn);
                chk($sformatf("sm%0d", d), ob[d].sm, e.sm);
                chk($sformatf("sr%0d", d), ob[d].sr, e.sr);
                chk($sformatf("sc%0d", d), ob[d].sc, e.sc);
                chk($sformatf("first%0d", d), ob[d].first, e.first);
                chk($sformatf("last%0d", d), ob[d].last, e.last);
            end else begin
                chk($sformatf("idle_fields%0d", d),
                    ob[d].sn | ob[d].sm | ob[d].sr | ob[d].sc
                    | AW'(ob[d].first) | AW'(ob[d].last), 0);
            end
`ifdef CONV_LAYER_SEQ_PERF_EN
            chk($sformatf("pcyc%0d", d), ob[d].pc, md[d].pc);
            chk($sformatf("ptil%0d", d), ob[d].pt, md[d].pt);
`else
            chk($sformatf("pcyc%0d", d), ob[d].pc, 0);
            chk($sformatf("ptil%0d", d), ob[d].pt, 0);
`endif
            if (ob[d].start === 1'b1) begin
                starts[d]++;
                if (acc[d] > 0) spacing[d] = cyc - acc[d] + 1;
            end
            if (ob[d].done === 1'b1) dones[d]++;
        end
    end

    // Tile engines: tile_done after a latency, optional stray done pulse.
    initial begin
        int cnt[2];
        int inj[2];
        logic nd;
        cnt = '{0, 0};
        inj = '{0, 0};
        td_v = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                nd = 1'b0;
                if (cnt[d] > 0) begin
                    cnt[d]--;
                    if (cnt[d] == 0) begin
                        nd = 1'b1;
                        if (en_inj && $urandom_range(2, 0) == 0) inj[d] = 2;
                    end
                end else if (inj[d] > 0) begin
                    inj[d]--;
                    if (inj[d] == 0) nd = 1'b1;
                end
                if (ob[d].start === 1'b1)
                    cnt[d] = rand_lat ? int'($urandom_range(12, 1)) : 10;
                td_v[d] = nd;
            end
        end
    end

    task automatic run_layer(input string tag, input bit junk);
        int s0[2];
        int d0[2];
        int n;
        s0 = starts;
        d0 = dones;
        g_start = 1'b1;
        tick();
        g_start = 1'b0;
        chk({tag, "_first_start"}, ob[0].start, 1);
        chk({tag, "_origin"},
            ob[0].bn | ob[0].bm | ob[0].br | ob[0].bc, 0);
        n = 0;
        while (!(dones[0] != d0[0] && dones[1] != d0[1] &&
                 !ob[0].busy && !ob[1].busy) && n < 4000) begin
            g_start = junk && ob[0].busy && ob[1].busy &&
                      ($urandom_range(7, 0) == 0);
            tick();
            n++;
        end
        g_start = 1'b0;
        if (n >= 4000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=%0d want<4000", tag, n);
        end
        chk({tag, "_tiles_a"}, starts[0] - s0[0], 12);
        chk({tag, "_tiles_b"}, starts[1] - s0[1], 12);
        chk({tag, "_ldone_a"}, dones[0] - d0[0], 1);
        chk({tag, "_ldone_b"}, dones[1] - d0[1], 1);
    endtask

    initial begin
        int s0;
        int d0[2];
        int n;
        for (int n_ = 0; n_ < N; n_ += TN)
            for (int r = 0; r < R; r += TR)
                for (int c = 0; c < C; c += TC)
                    for (int m = 0; m < M; m += TM) begin
                        tile_t t;
                        t.bn = AW'(n_);
                        t.bm = AW'(m);
                        t.br = AW'(r);
                        t.bc = AW'(c);
                        t.sn = AW'((N - n_ < TN) ? N - n_ : TN);
                        t.sm = AW'((M - m < TM) ? M - m : TM);
                        t.sr = AW'((R - r < TR) ? R - r : TR);
                        t.sc = AW'((C - c < TC) ? C - c : TC);
                        t.first = (m == 0);
                        t.last  = (m + TM >= M);
                        tl.push_back(t);
                    end
        chk("model_ntiles", tl.size(), 12);
        chk("model_row_sz2", tl[4].sr, 4);
        chk("model_row_base2", tl[4].br, 16);
        chk("model_m_sz1", tl[1].sm, 8);
        chk("model_first1", tl[1].first, 0);
        chk("model_last1", tl[1].last, 1);
        chk("model_first0", tl[0].first, 1);
        chk("model_n_last", tl[11].bn, 16);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_a", |ob[0], 0);
        chk("reset_b", |ob[1], 0);

        en_inj = 1'b1;
        rand_lat = 1'b1;
        run_layer("rand", 1'b1);

        en_inj = 1'b0;
        rand_lat = 1'b0;
        repeat (5) tick();
        run_layer("perf", 1'b0);
        chk("spacing_gap4", spacing[0], 6);
        chk("spacing_gap0", spacing[1], 2);
`ifdef CONV_LAYER_SEQ_PERF_EN
        chk("perf_tiles_a", ob[0].pt, 12);
        chk("perf_tiles_b", ob[1].pt, 12);
        chk("perf_cyc_a", ob[0].pc, 187);
        chk("perf_cyc_b", ob[1].pc, 143);
`else
        chk("perf_off_a", ob[0].pc | 32'(ob[0].pt), 0);
        chk("perf_off_b", ob[1].pc | 32'(ob[1].pt), 0);
`endif

        repeat (5) tick();
        s0 = starts[0];
        d0 = dones;
        g_start = 1'b1;
        tick();
        g_start = 1'b0;
        n = 0;
        while (starts[0] - s0 < 5 && n < 1000) begin
            tick();
            n++;
        end
        chk("abort_reach_tile5", starts[0] - s0, 5);
        repeat (3) tick();
        g_abort = 1'b1;
        tick();
        g_abort = 1'b0;
        chk("abort_busy_a", ob[0].busy, 0);
        chk("abort_busy_b", ob[1].busy, 0);
        chk("abort_base_a", ob[0].bn | ob[0].bm | ob[0].br | ob[0].bc, 0);
        repeat (30) tick();
        chk("abort_no_done_a", dones[0] - d0[0], 0);
        chk("abort_no_done_b", dones[1] - d0[1], 0);

        rand_lat = 1'b1;
        en_inj = 1'b1;
        run_layer("restart", 1'b1);

        g_start = 1'b1;
        tick();
        g_start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_a", |ob[0], 0);
        chk("midrst_b", |ob[1], 0);
        chk("midrst_ptiles", ob[0].pt, 0);
        repeat (20) tick();
        chk("midrst_stays_idle", ob[0].busy | ob[1].busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
